dvp_frame_tx: RTL and testbench

DVP_FRAME_TX -- requirements
Module: dvp_frame_tx

---
 rtl/dvp_tx_pkg.sv | 43 ++++
 rtl/dvp_pattern_lut.sv | 45 ++++
 rtl/dvp_frame_tx.sv | 210 +++++++++++++++++++++
 tb/tb_dvp_frame_tx.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dvp_tx_pkg.sv
// Shared types and constants for the DVP test-pattern transmitter:
// FSM state encoding, pattern select codes and the RGB565 colour-bar palette.
package dvp_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBACK  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_HBLANK = 3'd4,
        ST_VFRONT = 3'd5
    } dvp_state_t;

    localparam logic [1:0] PAT_BARS     = 2'd0;
    localparam logic [1:0] PAT_GRADIENT = 2'd1;
    localparam logic [1:0] PAT_SOLID    = 2'd2;
    localparam logic [1:0] PAT_CHECKER  = 2'd3;

    localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
    localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
    localparam logic [15:0] BAR_CYAN    = 16'h07FF;
    localparam logic [15:0] BAR_GREEN   = 16'h07E0;
    localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
    localparam logic [15:0] BAR_RED     = 16'hF800;
    localparam logic [15:0] BAR_BLUE    = 16'h001F;
    localparam logic [15:0] BAR_BLACK   = 16'h0000;

    function automatic logic [15:0] bar_colour(input logic [2:0] idx);
        logic [15:0] c;
        case (idx)
            3'd0:    c = BAR_WHITE;
            3'd1:    c = BAR_YELLOW;
            3'd2:    c = BAR_CYAN;
            3'd3:    c = BAR_GREEN;
            3'd4:    c = BAR_MAGENTA;
            3'd5:    c = BAR_RED;
            3'd6:    c = BAR_BLUE;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/dvp_pattern_lut.sv
// Combinational RGB565 pattern generator: maps pixel (x, y), pattern select
// and the solid colour to one pixel value.
module dvp_pattern_lut
    import dvp_tx_pkg::*;
#(
    parameter int H_PIXEL = 640,
    parameter int XW      = 10,
    parameter int YW      = 9
) (
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    input  logic [1:0]    sel,
    input  logic [15:0]   solid,
    output logic [15:0]   rgb
);

    // Narrow lines still get eight bars; the last bar takes the remainder.
    localparam int BAR_W = (H_PIXEL >= 8) ? H_PIXEL / 8 : 1;

    int unsigned bar;
    logic [2:0]  bar_idx;
    logic [4:0]  grad_x;
    logic [5:0]  grad_y;
    logic        chk_x;
    logic        chk_y;

    always_comb begin
        bar     = 32'(x) / 32'(BAR_W);
        bar_idx = (bar > 32'd7) ? 3'd7 : bar[2:0];
        grad_x  = 5'(32'(x) >> 3);
        grad_y  = 6'(32'(y) >> 2);
        chk_x   = 1'(32'(x) >> 4);
        chk_y   = 1'(32'(y) >> 4);

        rgb = 16'h0000;
        case (sel)
            PAT_BARS:     rgb = bar_colour(bar_idx);
            PAT_GRADIENT: rgb = {grad_x, grad_y, grad_x};
            PAT_SOLID:    rgb = solid;
            PAT_CHECKER:  rgb = (chk_x ^ chk_y) ? 16'hFFFF : 16'h0000;
            default:      rgb = 16'h0000;
        endcase
    end

endmodule

// File: rtl/dvp_frame_tx.sv
// DVP frame transmitter: emits vsync / href / 8-bit data framing of a test
// pattern, two bytes per RGB565 pixel. Optional DVP_TX_SCROLL_EN scrolls x per frame.
module dvp_frame_tx
    import dvp_tx_pkg::*;
#(
    parameter int H_PIXEL      = 640,
    parameter int V_PIXEL      = 480,
    parameter int H_BLANK      = 288,
    parameter int VSYNC_LINES  = 4,
    parameter int VBACK_LINES  = 18,
    parameter int VFRONT_LINES = 8
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        tx_en,
    input  logic [1:0]  pattern_sel,
    input  logic [15:0] solid_rgb,
    output logic        cam_vsync,
    output logic        cam_href,
    output logic [7:0]  cam_data,
    output logic        frame_done,
    output logic        busy,
    output logic [2:0]  dbg_state
);

    localparam int ACT_LEN  = 2 * H_PIXEL;
    localparam int LINE_LEN = 2 * H_PIXEL + H_BLANK;
    localparam int CW       = $clog2(LINE_LEN);
    localparam int XW       = (H_PIXEL > 1) ? $clog2(H_PIXEL) : 1;
    localparam int YW       = (V_PIXEL > 1) ? $clog2(V_PIXEL) : 1;
    localparam int MAXL_A   = (VSYNC_LINES > VBACK_LINES) ? VSYNC_LINES : VBACK_LINES;
    localparam int MAXL     = (MAXL_A > VFRONT_LINES) ? MAXL_A : VFRONT_LINES;
    localparam int LW       = (MAXL > 1) ? $clog2(MAXL) : 1;

    dvp_state_t  state, state_nx;
    logic [CW-1:0] cyc, cyc_nx;
    logic [LW-1:0] lines, lines_nx;
    logic [XW-1:0] x, x_nx, x_pix;
    logic [YW-1:0] y, y_nx;
    logic          byte_lo, byte_lo_nx;
    logic [1:0]    sel_q, sel_nx;
    logic [15:0]   solid_q, solid_nx;
    logic [15:0]   pix_rgb;
    logic          line_end;
    logic          frame_end;

    assign line_end  = (cyc == CW'(LINE_LEN - 1));
    assign dbg_state = state;

    always_comb begin
        state_nx   = state;
        cyc_nx     = cyc;
        lines_nx   = lines;
        x_nx       = x;
        y_nx       = y;
        byte_lo_nx = byte_lo;
        sel_nx     = sel_q;
        solid_nx   = solid_q;
        frame_end  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (tx_en) begin
                    state_nx = ST_VSYNC;
                    cyc_nx   = '0;
                    lines_nx = '0;
                    sel_nx   = pattern_sel;
                    solid_nx = solid_rgb;
                end
            end
            ST_VSYNC: begin
                cyc_nx = line_end ? '0 : cyc + CW'(1);
                if (line_end) begin
                    if (lines == LW'(VSYNC_LINES - 1)) begin
                        state_nx = ST_VBACK;
                        lines_nx = '0;
                    end else begin
                        lines_nx = lines + LW'(1);
                    end
                end
            end
            ST_VBACK: begin
                cyc_nx = line_end ? '0 : cyc + CW'(1);
                if (line_end) begin
                    if (lines == LW'(VBACK_LINES - 1)) begin
                        state_nx   = ST_ACTIVE;
                        lines_nx   = '0;
                        x_nx       = '0;
                        y_nx       = '0;
                        byte_lo_nx = 1'b0;
                    end else begin
                        lines_nx = lines + LW'(1);
                    end
                end
            end
            ST_ACTIVE: begin
                // x advances after the low byte so each pixel spans two cycles.
                cyc_nx     = cyc + CW'(1);
                byte_lo_nx = ~byte_lo;
                if (byte_lo) begin
                    x_nx = (x == XW'(H_PIXEL - 1)) ? '0 : x + XW'(1);
                end
                if (cyc == CW'(ACT_LEN - 1)) begin
                    state_nx = ST_HBLANK;
                end
            end
            ST_HBLANK: begin
                cyc_nx = line_end ? '0 : cyc + CW'(1);
                if (line_end) begin
                    byte_lo_nx = 1'b0;
                    if (y == YW'(V_PIXEL - 1)) begin
                        state_nx = ST_VFRONT;
                        y_nx     = '0;
                        lines_nx = '0;
                    end else begin
                        state_nx = ST_ACTIVE;
                        y_nx     = y + YW'(1);
                    end
                end
            end
            ST_VFRONT: begin
                cyc_nx = line_end ? '0 : cyc + CW'(1);
                if (line_end) begin
                    if (lines == LW'(VFRONT_LINES - 1)) begin
                        frame_end = 1'b1;
                        lines_nx  = '0;
                        if (tx_en) begin
                            state_nx = ST_VSYNC;
                            sel_nx   = pattern_sel;
                            solid_nx = solid_rgb;
                        end else begin
                            state_nx = ST_IDLE;
                        end
                    end else begin
                        lines_nx = lines + LW'(1);
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

`ifdef DVP_TX_SCROLL_EN
    logic [XW-1:0] scroll_off;
    logic [XW:0]   x_sum;

    always_comb begin
        x_sum = {1'b0, x_nx} + {1'b0, scroll_off};
        x_pix = (x_sum >= (XW+1)'(H_PIXEL)) ? XW'(x_sum - (XW+1)'(H_PIXEL)) : x_sum[XW-1:0];
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            scroll_off <= '0;
        end else if (frame_end) begin
            scroll_off <= (scroll_off == XW'(H_PIXEL - 1)) ? '0 : scroll_off + XW'(1);
        end
    end
`else
    assign x_pix = x_nx;
`endif

    dvp_pattern_lut #(
        .H_PIXEL (H_PIXEL),
        .XW      (XW),
        .YW      (YW)
    ) u_pattern_lut (
        .x     (x_pix),
        .y     (y_nx),
        .sel   (sel_q),
        .solid (solid_q),
        .rgb   (pix_rgb)
    );

    // Outputs are registered from next-state values so they line up with the state register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state      <= ST_IDLE;
            cyc        <= '0;
            lines      <= '0;
            x          <= '0;
            y          <= '0;
            byte_lo    <= 1'b0;
            sel_q      <= '0;
            solid_q    <= '0;
            cam_vsync  <= 1'b0;
            cam_href   <= 1'b0;
            cam_data   <= 8'h00;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nx;
            cyc        <= cyc_nx;
            lines      <= lines_nx;
            x          <= x_nx;
            y          <= y_nx;
            byte_lo    <= byte_lo_nx;
            sel_q      <= sel_nx;
            solid_q    <= solid_nx;
            cam_vsync  <= (state_nx == ST_VSYNC);
            cam_href   <= (state_nx == ST_ACTIVE);
            cam_data   <= (state_nx != ST_ACTIVE) ? 8'h00 :
                          (byte_lo_nx ? pix_rgb[7:0] : pix_rgb[15:8]);
            frame_done <= (state_nx == ST_VFRONT) && (cyc_nx == CW'(LINE_LEN - 1)) &&
                          (lines_nx == LW'(VFRONT_LINES - 1));
            busy       <= (state_nx != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_dvp_frame_tx.sv
// Directed bench for dvp_frame_tx on a 16x4 frame (line 36, frame 252 cycles);
// expectations follow DVP_TX_SCROLL_EN when it is defined.
module tb_dvp_frame_tx;

    localparam int H     = 16;
    localparam int V     = 4;
    localparam int LINE  = 36;
    localparam int FRAME = 252;

`ifdef DVP_TX_SCROLL_EN
    localparam logic [15:0] B_PIX1 = 16'hFFE0;
`else
    localparam logic [15:0] B_PIX1 = 16'hFFFF;
`endif

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        tx_en = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic [15:0] solid_rgb = 16'h0000;
    logic        cam_vsync;
    logic        cam_href;
    logic [7:0]  cam_data;
    logic        frame_done;
    logic        busy;
    logic [2:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    int scroll_off = 0;

    int vs_cycles, frame_cycles, zero_viol, busy_low;
    int bursts[$];
    logic [7:0] bytes_q[$];
    logic [7:0] exp_q[$];

    logic [15:0] bar_tab [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    logic [7:0]  bar_hdr [10] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                                  8'hE0, 8'hFF, 8'hE0, 8'h07, 8'hFF};

    dvp_frame_tx #(
        .H_PIXEL      (H),
        .V_PIXEL      (V),
        .H_BLANK      (4),
        .VSYNC_LINES  (1),
        .VBACK_LINES  (1),
        .VFRONT_LINES (1)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .tx_en       (tx_en),
        .pattern_sel (pattern_sel),
        .solid_rgb   (solid_rgb),
        .cam_vsync   (cam_vsync),
        .cam_href    (cam_href),
        .cam_data    (cam_data),
        .frame_done  (frame_done),
        .busy        (busy),
        .dbg_state   (dbg_state)
    );

    // Clock and reset
    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference pixel model
    function automatic logic [15:0] exp_pix(input logic [1:0] sel, input logic [15:0] solid,
                                            input int x, input int y, input int off);
        int xe;
        int bi;
        logic [7:0] xb;
        logic [7:0] yb;
        xe = (x + off) % H;
        bi = xe / 2;
        if (bi > 7) bi = 7;
        xb = 8'(xe);
        yb = 8'(y);
        case (sel)
            2'd0:    return bar_tab[bi];
            2'd1:    return {xb[7:3], yb[7:2], xb[7:3]};
            2'd2:    return solid;
            default: return (xb[4] ^ yb[4]) ? 16'hFFFF : 16'h0000;
        endcase
    endfunction

    // Driver: run one whole frame, optionally changing inputs at cycle chg_cycle
    task automatic run_frame(input int chg_cycle, input logic [1:0] chg_sel,
                             input logic [15:0] chg_rgb, input logic chg_en);
        int  cur;
        bit  done;
        vs_cycles = 0; zero_viol = 0; frame_cycles = 0; busy_low = 0;
        cur = 0; done = 0;
        bursts.delete();
        bytes_q.delete();
        for (int c = 1; c <= 600 && !done; c++) begin
            tick();
            if (cam_vsync) vs_cycles++;
            if (!busy) busy_low++;
            if (cam_href) begin
                cur++;
                bytes_q.push_back(cam_data);
            end else begin
                if (cur > 0) bursts.push_back(cur);
                cur = 0;
                if (cam_data !== 8'h00) zero_viol++;
            end
            if (frame_done) begin
                frame_cycles = c;
                done = 1;
            end
            if (c == chg_cycle) begin
                pattern_sel = chg_sel;
                solid_rgb   = chg_rgb;
                tx_en       = chg_en;
            end
        end
        chk("frame_done_seen", 32'(done), 32'd1);
`ifdef DVP_TX_SCROLL_EN
        if (done) scroll_off = (scroll_off + 1) % H;
`endif
    endtask

    // Scoreboard: framing plus byte stream against the expected queue
    task automatic check_frame(input string tag, input logic [1:0] sel, input logic [15:0] solid,
                               input int off);
        int mism;
        int n;
        logic [15:0] p;
        exp_q.delete();
        for (int yy = 0; yy < V; yy++) begin
            for (int xx = 0; xx < H; xx++) begin
                p = exp_pix(sel, solid, xx, yy, off);
                exp_q.push_back(p[15:8]);
                exp_q.push_back(p[7:0]);
            end
        end
        chk({tag, "_vsync_cycles"}, 32'(vs_cycles), 32'(LINE));
        chk({tag, "_href_bursts"}, 32'(bursts.size()), 32'(V));
        for (int i = 0; i < V; i++) begin
            chk($sformatf("%s_burst%0d_len", tag, i),
                (i < bursts.size()) ? 32'(bursts[i]) : 32'hFFFF_FFFF, 32'(2 * H));
        end
        chk({tag, "_byte_count"}, 32'(bytes_q.size()), 32'(exp_q.size()));
        mism = 0;
        n = (bytes_q.size() < exp_q.size()) ? bytes_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (bytes_q[i] !== exp_q[i]) mism++;
        end
        chk({tag, "_byte_mismatches"}, 32'(mism), 32'd0);
        chk({tag, "_data_zero_outside_href"}, 32'(zero_viol), 32'd0);
        chk({tag, "_frame_cycles"}, 32'(frame_cycles), 32'(FRAME));
        chk({tag, "_busy_low_cycles"}, 32'(busy_low), 32'd0);
    endtask

    initial begin
        int activity;
        int off_now;

        // Reset state
        sys_rst = 1'b1;
        repeat (3) tick();
        chk("rst_vsync", 32'(cam_vsync), 32'd0);
        chk("rst_href", 32'(cam_href), 32'd0);
        chk("rst_data", 32'(cam_data), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
        sys_rst = 1'b0;
        tick();
        chk("idle_busy_without_en", 32'(busy), 32'd0);

        // Frame A: colour bars; solid changes mid-frame while bars stay selected
        pattern_sel = 2'd0;
        tx_en = 1'b1;
        off_now = scroll_off;
        run_frame(100, 2'd0, 16'hABCD, 1'b1);
        check_frame("A", 2'd0, 16'h0000, off_now);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("A_line0_byte%0d", i),
                (i < bytes_q.size()) ? 32'(bytes_q[i]) : 32'hFFFF_FFFF, 32'(bar_hdr[i]));
        end

        // Frame B: bars again; mid-frame switch to solid must wait for the next frame
        off_now = scroll_off;
        run_frame(100, 2'd2, 16'hABCD, 1'b1);
        check_frame("B", 2'd0, 16'h0000, off_now);
        chk("B_pix0", (bytes_q.size() >= 4) ? 32'({bytes_q[0], bytes_q[1]}) : 32'hFFFF_FFFF, 32'hFFFF);
        chk("B_pix1", (bytes_q.size() >= 4) ? 32'({bytes_q[2], bytes_q[3]}) : 32'hFFFF_FFFF, 32'(B_PIX1));

        // Frame C: solid ABCD; 1234 arrives mid-frame
        off_now = scroll_off;
        run_frame(100, 2'd2, 16'h1234, 1'b1);
        check_frame("C", 2'd2, 16'hABCD, off_now);
        chk("C_byte0", (bytes_q.size() >= 2) ? 32'(bytes_q[0]) : 32'hFFFF_FFFF, 32'hAB);
        chk("C_byte1", (bytes_q.size() >= 2) ? 32'(bytes_q[1]) : 32'hFFFF_FFFF, 32'hCD);

        // Frame D: solid 1234; tx_en drops during line 1 and the frame still completes
        off_now = scroll_off;
        run_frame(120, 2'd1, 16'h1234, 1'b0);
        check_frame("D", 2'd2, 16'h1234, off_now);

        activity = 0;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (busy || cam_vsync || cam_href || frame_done || (cam_data !== 8'h00)) activity++;
        end
        chk("idle_after_stop_activity", 32'(activity), 32'd0);
        chk("idle_after_stop_state", 32'(dbg_state), 32'd0);

        // Frame E: gradient latched at IDLE->VSYNC; checkerboard queued for F
        tx_en = 1'b1;
        off_now = scroll_off;
        run_frame(120, 2'd3, 16'h0000, 1'b1);
        check_frame("E", 2'd1, 16'h1234, off_now);

        // Frame F: checkerboard; bars queued for the interrupted frame
        off_now = scroll_off;
        run_frame(120, 2'd0, 16'h0000, 1'b1);
        check_frame("F", 2'd3, 16'h0000, off_now);

        // Reset during ACTIVE of line 0
        for (int c = 0; c < 80; c++) tick();
        chk("pre_rst_href", 32'(cam_href), 32'd1);
        sys_rst = 1'b1;
        tick();
        chk("midrst_vsync", 32'(cam_vsync), 32'd0);
        chk("midrst_href", 32'(cam_href), 32'd0);
        chk("midrst_data", 32'(cam_data), 32'd0);
        chk("midrst_frame_done", 32'(frame_done), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        sys_rst = 1'b0;
        scroll_off = 0;

        // Restart after reset yields a full frame
        off_now = scroll_off;
        run_frame(0, 2'd0, 16'h0000, 1'b1);
        check_frame("R", 2'd0, 16'h0000, off_now);

        tx_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
